// File: rtl/video_timing_controller.sv
// Raster timing generator: coupled horizontal/vertical segment machines that
// produce registered sync, data-enable, pixel coordinates and line/frame strobes.
module video_timing_controller #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int X_W      = 12,
  parameter int Y_W      = 11
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           run,
  output logic           idle,
  output logic [1:0]     h_state,
  output logic [1:0]     v_state,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_start
);

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int H_MAX = max4(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_MAX = max4(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_CW  = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int V_CW  = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  typedef enum logic [1:0] {
    SEG_BP     = 2'b00,
    SEG_ACTIVE = 2'b01,
    SEG_FP     = 2'b10,
    SEG_SYNC   = 2'b11
  } seg_e;

  function automatic seg_e next_seg(seg_e s);
    case (s)
      SEG_BP:     return SEG_ACTIVE;
      SEG_ACTIVE: return SEG_FP;
      SEG_FP:     return SEG_SYNC;
      default:    return SEG_BP;
    endcase
  endfunction

  function automatic logic [H_CW-1:0] h_last(seg_e s);
    case (s)
      SEG_BP:     return H_CW'(H_BP - 1);
      SEG_ACTIVE: return H_CW'(H_ACTIVE - 1);
      SEG_FP:     return H_CW'(H_FP - 1);
      default:    return H_CW'(H_SYNC - 1);
    endcase
  endfunction

  function automatic logic [V_CW-1:0] v_last(seg_e s);
    case (s)
      SEG_BP:     return V_CW'(V_BP - 1);
      SEG_ACTIVE: return V_CW'(V_ACTIVE - 1);
      SEG_FP:     return V_CW'(V_FP - 1);
      default:    return V_CW'(V_SYNC - 1);
    endcase
  endfunction

  logic            idle_q, idle_d;
  seg_e            h_seg_q, h_seg_d;
  seg_e            v_seg_q, v_seg_d;
  logic [H_CW-1:0] h_cnt_q, h_cnt_d;
  logic [V_CW-1:0] v_cnt_q, v_cnt_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            de_q, de_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;

  logic h_end, v_end, line_end, frame_end;

  always_comb begin
    h_end     = (h_cnt_q == h_last(h_seg_q));
    v_end     = (v_cnt_q == v_last(v_seg_q));
    line_end  = h_end && (h_seg_q == SEG_SYNC);
    frame_end = line_end && v_end && (v_seg_q == SEG_SYNC);
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block infers a latch.
    idle_d        = 1'b1;
    h_seg_d       = SEG_BP;
    v_seg_d       = SEG_BP;
    h_cnt_d       = '0;
    v_cnt_d       = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (idle_q) begin
      if (run) begin
        idle_d        = 1'b0;
        line_start_d  = 1'b1;
        frame_start_d = 1'b1;
      end
    end else if (!(frame_end && !run)) begin
      // Running, or at a frame boundary with run still high: keep sequencing.
      idle_d  = 1'b0;
      v_seg_d = v_seg_q;
      v_cnt_d = v_cnt_q;
      if (h_end) begin
        h_seg_d = next_seg(h_seg_q);
        h_cnt_d = '0;
      end else begin
        h_seg_d = h_seg_q;
        h_cnt_d = h_cnt_q + 1'b1;
      end
      if (line_end) begin
        line_start_d = 1'b1;
        if (v_end) begin
          v_seg_d = next_seg(v_seg_q);
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end
      frame_start_d = frame_end;
    end

    // Idle parks both machines in BP with zero counts, so these decode to reset values.
    hsync_d = (h_seg_d == SEG_SYNC) ? HS_POL : ~HS_POL;
    vsync_d = (v_seg_d == SEG_SYNC) ? VS_POL : ~VS_POL;
    de_d    = (h_seg_d == SEG_ACTIVE) && (v_seg_d == SEG_ACTIVE);
    x_d     = (h_seg_d == SEG_ACTIVE) ? X_W'(h_cnt_d) : '0;
    y_d     = (v_seg_d == SEG_ACTIVE) ? Y_W'(v_cnt_d) : '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_q        <= 1'b1;
      h_seg_q       <= SEG_BP;
      v_seg_q       <= SEG_BP;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      idle_q        <= idle_d;
      h_seg_q       <= h_seg_d;
      v_seg_q       <= v_seg_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign idle        = idle_q;
  assign h_state     = h_seg_q;
  assign v_state     = v_seg_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_controller.sv
// Scoreboard bench for video_timing_controller with an 8x6 raster; a second
// instance with inverted sync polarity runs in lockstep on the same inputs.
module tb_video_timing_controller;

  localparam int X_W = 3;
  localparam int Y_W = 2;
  localparam int FRAME = 48;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run   = 1'b0;

  logic           idle, hsync, vsync, de, line_start, frame_start;
  logic [1:0]     h_state, v_state;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;

  logic           idle_n, hsync_n, vsync_n, de_n, line_start_n, frame_start_n;
  logic [1:0]     h_state_n, v_state_n;
  logic [X_W-1:0] x_n;
  logic [Y_W-1:0] y_n;

  always #5 clock = ~clock;

  video_timing_controller #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .X_W(X_W), .Y_W(Y_W)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .idle(idle),
    .h_state(h_state), .v_state(v_state), .hsync(hsync), .vsync(vsync),
    .de(de), .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  video_timing_controller #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .X_W(X_W), .Y_W(Y_W)
  ) dut_n (
    .clock(clock), .reset(reset), .run(run), .idle(idle_n),
    .h_state(h_state_n), .v_state(v_state_n), .hsync(hsync_n), .vsync(vsync_n),
    .de(de_n), .x(x_n), .y(y_n), .line_start(line_start_n), .frame_start(frame_start_n)
  );

  typedef struct packed {
    logic       idle;
    logic [1:0] h_state;
    logic [1:0] v_state;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [2:0] x;
    logic [1:0] y;
    logic       line_start;
    logic       frame_start;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Hand-written phase tables for one 8-cycle line and one 6-line frame.
  logic [1:0] h_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
  logic [1:0] v_tab [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};

  bit m_idle = 1'b1;
  int m_p    = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  function automatic exp_t expected();
    exp_t e;
    int col, line;
    e = '0;
    e.idle  = 1'b1;
    e.hsync = 1'b0;
    e.vsync = 1'b0;
    if (!m_idle) begin
      col           = m_p % 8;
      line          = m_p / 8;
      e.idle        = 1'b0;
      e.h_state     = h_tab[col];
      e.v_state     = v_tab[line];
      e.hsync       = (e.h_state == 2'b11);
      e.vsync       = (e.v_state == 2'b11);
      e.de          = (e.h_state == 2'b01) && (e.v_state == 2'b01);
      e.x           = (e.h_state == 2'b01) ? 3'(col - 1) : 3'd0;
      e.y           = (e.v_state == 2'b01) ? 2'(line - 1) : 2'd0;
      e.line_start  = (col == 0);
      e.frame_start = (m_p == 0);
    end
    return e;
  endfunction

  // Apply inputs for one edge, advance the reference raster, queue the response.
  task automatic step(input bit run_v, input bit reset_v);
    run   = run_v;
    reset = reset_v;
    @(posedge clock);
    if (reset_v) begin
      m_idle = 1'b1;
      m_p    = 0;
    end else if (m_idle) begin
      if (run_v) begin
        m_idle = 1'b0;
        m_p    = 0;
      end
    end else if (m_p == FRAME - 1) begin
      if (run_v) m_p = 0;
      else       m_idle = 1'b1;
    end else begin
      m_p++;
    end
    exp_q.push_back(expected());
    @(negedge clock);
  endtask

  task automatic steps(input int n, input bit run_v, input bit reset_v);
    for (int i = 0; i < n; i++) step(run_v, reset_v);
  endtask

  exp_t e_mon;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      check("idle",        idle,        e_mon.idle);
      check("h_state",     h_state,     e_mon.h_state);
      check("v_state",     v_state,     e_mon.v_state);
      check("hsync",       hsync,       e_mon.hsync);
      check("vsync",       vsync,       e_mon.vsync);
      check("de",          de,          e_mon.de);
      check("x",           x,           e_mon.x);
      check("y",           y,           e_mon.y);
      check("line_start",  line_start,  e_mon.line_start);
      check("frame_start", frame_start, e_mon.frame_start);
      check("hsync_n",     hsync_n,     !e_mon.hsync);
      check("vsync_n",     vsync_n,     !e_mon.vsync);
      check("de_n",        de_n,        e_mon.de);
      check("frame_start_n", frame_start_n, e_mon.frame_start);
    end
  end

  initial begin
    @(negedge clock);
    // Reset, then parked with run low.
    steps(3, 1'b0, 1'b1);
    steps(20, 1'b0, 1'b0);
    // Three back-to-back frames, then run drops and the frame in flight completes.
    steps(3 * FRAME + 1, 1'b1, 1'b0);
    steps(FRAME + 10, 1'b0, 1'b0);
    // Run dropped at frame cycle 10: the frame still finishes, then parks.
    steps(11, 1'b1, 1'b0);
    steps(FRAME + 5, 1'b0, 1'b0);
    // Re-raise run, then reset during an active pixel while run stays high.
    steps(12, 1'b1, 1'b0);
    step(1'b1, 1'b1);
    steps(10, 1'b1, 1'b0);
    steps(FRAME + 5, 1'b0, 1'b0);
    @(negedge clock);
    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
